sobel_stream_3x3: RTL and testbench

- Downstream consumer of the 3x3 window memory.
- Sequences the window reads by driving `rd`, and takes the nine window pixels the cycle after each read.
- Computes the Sobel gradient magnitude |Gx|+|Gy| in a 3-stage pipeline.
- Emits one 8-bit result per window as `pixelw`/`wr` for the result buffer, and signals end of frame.

---
 rtl/sobel_stream_3x3.sv | 211 +++++++++++++++++++++
 tb/tb_sobel_stream_3x3.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_3x3.sv
// sobel_stream_3x3: streams 3x3 windows out of the window memory and computes
// the Sobel gradient magnitude |Gx|+|Gy| in a three-stage registered pipeline.
// It issues one read per output pixel, tracks each read through a valid shift
// register and emits one 8-bit result per window on pixelw/wr.
// Optional build macro: SOBEL_THRESH_EN. When it is defined, the result is
// binarised against THRESH (255 or 0). When it is not defined, the result is
// the magnitude saturated at 255.
// RD_LAT must be at least 1.
module sobel_stream_3x3 #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 32,
    parameter int RD_LAT = 1,
    parameter int THRESH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    input  logic [7:0] p3,
    input  logic [7:0] p4,
    input  logic [7:0] p5,
    input  logic [7:0] p6,
    input  logic [7:0] p7,
    input  logic [7:0] p8,
    input  logic [7:0] p9,
    output logic       rd,
    output logic [7:0] pixelw,
    output logic       wr,
    output logic       busy,
    output logic       done
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CW    = $clog2(TOTAL) + 1;
    localparam int VD    = RD_LAT + 3;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic            w_rd;
    logic            w_busy;
    logic            w_done;
    logic [CW-1:0]   r_rdCnt;
    logic [CW-1:0]   r_wrCnt;
    logic [CW-1:0]   w_wrCntNext;
    logic [VD-1:0]   r_vld;

    logic [9:0]      r_gxp;
    logic [9:0]      r_gxn;
    logic [9:0]      r_gyp;
    logic [9:0]      r_gyn;
    logic [9:0]      r_absX;
    logic [9:0]      r_absY;
    logic [7:0]      r_pix;

    logic [9:0]      w_gxp;
    logic [9:0]      w_gxn;
    logic [9:0]      w_gyp;
    logic [9:0]      w_gyn;
    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic [9:0]      w_absX;
    logic [9:0]      w_absY;
    logic [10:0]     w_sum;
    logic [7:0]      w_result;

    // A write in the current cycle already counts toward the total, so the
    // FSM can leave DRAIN on the cycle that carries the final write.
    assign w_wrCntNext = r_wrCnt + CW'(r_vld[VD-1]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control outputs; rd is gated combinationally by hold
    always_comb begin
        w_nextState = r_state;
        w_rd        = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = READ;
                end
            end
            READ: begin
                w_busy = 1'b1;
                w_rd   = !hold;
                if (w_rd && (r_rdCnt == CW'(TOTAL - 1))) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (w_wrCntNext == CW'(TOTAL)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Read and write counters, cleared when a new frame is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdCnt <= '0;
            r_wrCnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_rdCnt <= '0;
            r_wrCnt <= '0;
        end else begin
            if (w_rd) begin
                r_rdCnt <= r_rdCnt + 1'b1;
            end
            if (r_vld[VD-1]) begin
                r_wrCnt <= r_wrCnt + 1'b1;
            end
        end
    end

    // Valid shift register: bit k is rd delayed by k+1 cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[VD-2:0], w_rd};
        end
    end

    assign w_gxp = 10'(p3) + {1'b0, p6, 1'b0} + 10'(p9);
    assign w_gxn = 10'(p1) + {1'b0, p4, 1'b0} + 10'(p7);
    assign w_gyp = 10'(p7) + {1'b0, p8, 1'b0} + 10'(p9);
    assign w_gyn = 10'(p1) + {1'b0, p2, 1'b0} + 10'(p3);

    // Stage 1: weighted column/row sums, captured only when the window is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gxp <= '0;
            r_gxn <= '0;
            r_gyp <= '0;
            r_gyn <= '0;
        end else if (r_vld[RD_LAT-1]) begin
            r_gxp <= w_gxp;
            r_gxn <= w_gxn;
            r_gyp <= w_gyp;
            r_gyn <= w_gyn;
        end
    end

    assign w_gx   = $signed({1'b0, r_gxp}) - $signed({1'b0, r_gxn});
    assign w_gy   = $signed({1'b0, r_gyp}) - $signed({1'b0, r_gyn});
    assign w_absX = w_gx[10] ? 10'(-w_gx) : w_gx[9:0];
    assign w_absY = w_gy[10] ? 10'(-w_gy) : w_gy[9:0];

    // Stage 2: absolute gradients, free-running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_absX <= '0;
            r_absY <= '0;
        end else begin
            r_absX <= w_absX;
            r_absY <= w_absY;
        end
    end

    assign w_sum = {1'b0, r_absX} + {1'b0, r_absY};

`ifdef SOBEL_THRESH_EN
    assign w_result = (w_sum >= 11'(THRESH)) ? 8'hFF : 8'h00;
`else
    assign w_result = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
`endif

    // A threshold above the largest possible magnitude (2040) would force
    // every binarised result to 0; no hardware is generated for that case.
    generate
        if (THRESH > 2040) begin : g_threshUnreachable
        end
    endgenerate

    // Stage 3: result register, updated only for valid windows so it holds between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix <= '0;
        end else if (r_vld[VD-2]) begin
            r_pix <= w_result;
        end
    end

    assign rd     = w_rd;
    assign busy   = w_busy;
    assign done   = w_done;
    assign wr     = r_vld[VD-1];
    assign pixelw = r_pix;

endmodule

// File: tb/tb_sobel_stream_3x3.sv
// tb_sobel_stream_3x3: directed bench for sobel_stream_3x3 with a 4x2 frame.
// A window-memory model answers every rd one cycle later and pushes the
// expected result and its due cycle to a scoreboard queue; each wr pops it.
module tb_sobel_stream_3x3;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int N   = W * H;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hold;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic       rd;
    logic [7:0] pixelw;
    logic       wr;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] pix;
        int         cyc;
    } exp_t;

    exp_t expQ[$];

    int   nVec      = 0;
    int   nErr      = 0;
    int   cyc       = 0;
    int   rdTot     = 0;
    int   wrTot     = 0;
    int   doneTot   = 0;
    int   lastRdCyc = 0;
    int   lastWrCyc = 0;
    int   doneCyc   = 0;
    logic doneBusy;
    bit   pending   = 1'b0;
    int   pendCyc   = 0;
    int   winIdx    = 0;
    int   dFrame2;
    int   dFrame3;
    int   dFrame5;
    int   r0;
    int   w0;
    int   d0;

    always #5 clk = ~clk;

    sobel_stream_3x3 #(
        .IMG_W (W),
        .IMG_H (H),
        .RD_LAT(1),
        .THRESH(128)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .hold  (hold),
        .p1    (p1),
        .p2    (p2),
        .p3    (p3),
        .p4    (p4),
        .p5    (p5),
        .p6    (p6),
        .p7    (p7),
        .p8    (p8),
        .p9    (p9),
        .rd    (rd),
        .pixelw(pixelw),
        .wr    (wr),
        .busy  (busy),
        .done  (done)
    );

    // Reference Sobel magnitude on a packed window (byte i holds p(i+1))
    function automatic logic [7:0] sobelRef(input logic [71:0] w);
        int q[9];
        int gx;
        int gy;
        int s;
        for (int i = 0; i < 9; i++) q[i] = int'(w[8*i +: 8]);
        gx = (q[2] + 2*q[5] + q[8]) - (q[0] + 2*q[3] + q[6]);
        gy = (q[6] + 2*q[7] + q[8]) - (q[0] + 2*q[1] + q[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        s = gx + gy;
`ifdef SOBEL_THRESH_EN
        return (s >= 128) ? 8'hFF : 8'h00;
`else
        return (s > 255) ? 8'hFF : 8'(s);
`endif
    endfunction

    // Window table: three directed windows with hand-derived results, then random ones
    task automatic makeWin(input int idx, output logic [71:0] w, output logic [7:0] e);
        w = '0;
        case (idx)
            0: begin
                w = {9{8'd100}};
                e = 8'd0;
            end
            1: begin
                w[23:16] = 8'd255;
                w[47:40] = 8'd255;
                w[71:64] = 8'd255;
                e = 8'd255;
            end
            2: begin
                w[23:16] = 8'd10;
                w[47:40] = 8'd10;
                w[71:64] = 8'd10;
`ifdef SOBEL_THRESH_EN
                e = 8'd0;
`else
                e = 8'd40;
`endif
            end
            default: begin
                for (int i = 0; i < 9; i++) begin
                    if (idx % 2 == 1) w[8*i +: 8] = 8'($urandom_range(0, 40));
                    else              w[8*i +: 8] = 8'($urandom_range(0, 255));
                end
                e = sobelRef(w);
            end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nVec++;
        assert (obs === expv) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, settle, then observe and model
    task automatic applyStimulus(input logic s, input logic h);
        exp_t        e;
        logic [71:0] w;
        logic [7:0]  ev;
        @(negedge clk);
        start = s;
        hold  = h;
        #1;
        cyc++;
        if (rst) begin
            expQ.delete();
            pending = 1'b0;
        end else begin
            if (wr) begin
                wrTot++;
                lastWrCyc = cyc;
                checkOutput("wr_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("pixelw", 32'(pixelw), 32'(e.pix));
                    checkOutput("wr_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done) begin
                doneTot++;
                doneCyc  = cyc;
                doneBusy = busy;
            end
            if (pending) begin
                makeWin(winIdx, w, ev);
                winIdx++;
                {p9, p8, p7, p6, p5, p4, p3, p2, p1} = w;
                expQ.push_back('{ev, pendCyc + LAT});
            end
            pending = rd;
            pendCyc = cyc;
            if (rd) begin
                rdTot++;
                lastRdCyc = cyc;
            end
        end
    endtask

    // Full frame from a start pulse, optionally holding for holdLen cycles after read holdAfter
    task automatic runFrame(input int holdAfter, input int holdLen, output int dStart);
        int   rs;
        int   ws;
        int   ds;
        int   firstRd;
        int   firstWr;
        int   held;
        int   sc;
        logic h;
        rs = rdTot;
        ws = wrTot;
        ds = doneTot;
        firstRd = -1;
        firstWr = -1;
        held = 0;
        applyStimulus(1'b1, 1'b0);
        sc = cyc;
        for (int k = 0; k < 80 && doneTot == ds; k++) begin
            h = (holdLen > 0) && (rdTot - rs >= holdAfter) && (held < holdLen);
            if (h) held++;
            applyStimulus(1'b0, h);
            if (rd && firstRd < 0) firstRd = cyc;
            if (wr && firstWr < 0) firstWr = cyc;
        end
        checkOutput("done_seen", 32'(doneTot - ds), 32'd1);
        checkOutput("rd_count", 32'(rdTot - rs), 32'(N));
        checkOutput("wr_count", 32'(wrTot - ws), 32'(N));
        checkOutput("rd_span", 32'(lastRdCyc - firstRd), 32'(N - 1 + holdLen));
        checkOutput("wr_span", 32'(lastWrCyc - firstWr), 32'(N - 1 + holdLen));
        checkOutput("done_after_wr", 32'(doneCyc - lastWrCyc), 32'd1);
        checkOutput("busy_at_done", 32'(doneBusy), 32'd0);
        dStart = doneCyc - sc;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        {p9, p8, p7, p6, p5, p4, p3, p2, p1} = '0;

        // Reset state
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst_rd", 32'(rd), 32'd0);
        checkOutput("rst_wr", 32'(wr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pixelw", 32'(pixelw), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Frame 1: isolated single reads (flat, vertical edge, weak gradient, random)
        d0 = doneTot;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("rd_gated_by_hold", 32'(rd), 32'd0);
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("rd_single", 32'(rd), 32'd1);
            repeat (6) applyStimulus(1'b0, 1'b1);
        end
        checkOutput("frame1_done", 32'(doneTot - d0), 32'd1);
        checkOutput("frame1_idle_busy", 32'(busy), 32'd0);

        // Frame 2: back-to-back reads
        runFrame(0, 0, dFrame2);
        checkOutput("frame2_done_time", 32'(dFrame2), 32'(N + LAT + 1));

        // Frame 3: three hold cycles after the third read
        runFrame(3, 3, dFrame3);
        checkOutput("frame3_done_delay", 32'(dFrame3 - dFrame2), 32'd3);

        // Frame 4: reset after five reads abandons the frame
        r0 = rdTot;
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 40 && (rdTot - r0) < 5; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("rst_mid_reads", 32'(rdTot - r0), 32'd5);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_rd", 32'(rd), 32'd0);
        checkOutput("rst_mid_wr", 32'(wr), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        w0 = wrTot;
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
        repeat (12) applyStimulus(1'b0, 1'b0);
        checkOutput("no_wr_after_rst", 32'(wrTot - w0), 32'd0);
        checkOutput("idle_after_rst", 32'(busy), 32'd0);

        // Frame 5: complete frame after the abandoned one
        runFrame(0, 0, dFrame5);
        checkOutput("frame5_done_time", 32'(dFrame5), 32'(N + LAT + 1));

        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
